// File: rtl/sub8_bin_bout_stream.sv
// Streaming multi-limb subtractor: A - B over limb-serial operands, LS limb
// first. Borrow and the running all-zero flag carry across limbs in
// registers, and a single output register provides the valid/ready stage.
module sub8_bin_bout_stream #(
  parameter int width = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [width-1:0] I0,
  input  logic [width-1:0] I1,
  input  logic             BIN,
  input  logic             I_VALID,
  input  logic             I_LAST,
  output logic             I_READY,
  output logic [width-1:0] O,
  output logic             O_LAST,
  output logic             BOUT,
  output logic             ZERO,
  output logic             O_VALID,
  input  logic             O_READY
);

  typedef enum logic {ST_FIRST = 1'b0, ST_MID = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             borrow_q, zero_q;
  logic [width-1:0] o_q;
  logic             o_last_q, bout_q, zero_out_q, o_valid_q;

  logic             in_xfer, out_xfer;
  logic             bin_eff, limb_b, limb_zero, zacc;
  logic [width:0]   diff;

  assign in_xfer  = I_VALID & I_READY;
  assign out_xfer = o_valid_q & O_READY;

  // Limb arithmetic: borrow-in comes from BIN only on the first limb.
  always_comb begin
    bin_eff   = (state_q == ST_FIRST) ? BIN : borrow_q;
    diff      = {1'b0, I0} - {1'b0, I1} - {{width{1'b0}}, bin_eff};
    limb_b    = diff[width];
    limb_zero = (diff[width-1:0] == '0);
    zacc      = ((state_q == ST_FIRST) ? 1'b1 : zero_q) & limb_zero;
  end

  // State register.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) state_q <= ST_FIRST;
    else              state_q <= state_d;
  end

  // Next state: the last limb always returns to FIRST so the next op uses BIN.
  always_comb begin
    state_d = state_q;
    if (in_xfer) state_d = I_LAST ? ST_FIRST : ST_MID;
  end

  // Cross-limb borrow and zero accumulation; both hold while stalled.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
    end else if (in_xfer) begin
      borrow_q <= I_LAST ? 1'b0 : limb_b;
      zero_q   <= zacc;
    end
  end

  // Output register: loads on input transfer, drops valid once drained.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      o_q        <= '0;
      o_last_q   <= 1'b0;
      bout_q     <= 1'b0;
      zero_out_q <= 1'b0;
      o_valid_q  <= 1'b0;
    end else if (in_xfer) begin
      o_q        <= diff[width-1:0];
      o_last_q   <= I_LAST;
      bout_q     <= I_LAST & limb_b;
      zero_out_q <= I_LAST & zacc;
      o_valid_q  <= 1'b1;
    end else if (out_xfer) begin
      o_valid_q  <= 1'b0;
    end
  end

  // Outputs; ready depends on O_READY and registered state only, never I_VALID.
  always_comb begin
    I_READY = ~o_valid_q | O_READY;
    O       = o_q;
    O_LAST  = o_last_q;
    BOUT    = bout_q;
    ZERO    = zero_out_q;
    O_VALID = o_valid_q;
  end

endmodule

// File: tb/tb_sub8_bin_bout_stream.sv
// Directed bench for sub8_bin_bout_stream with hand-computed results.
module tb_sub8_bin_bout_stream;

  logic       CLK = 1'b0;
  logic       ASYNCRESETN = 1'b0;
  logic [7:0] I0 = '0, I1 = '0;
  logic       BIN = 1'b0, I_VALID = 1'b0, I_LAST = 1'b0, O_READY = 1'b1;
  logic       I_READY, O_LAST, BOUT, ZERO, O_VALID;
  logic [7:0] O;

  int n_chk = 0;
  int n_err = 0;

  sub8_bin_bout_stream #(.width(8)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I0(I0), .I1(I1), .BIN(BIN),
    .I_VALID(I_VALID), .I_LAST(I_LAST), .I_READY(I_READY), .O(O),
    .O_LAST(O_LAST), .BOUT(BOUT), .ZERO(ZERO), .O_VALID(O_VALID),
    .O_READY(O_READY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] o, input logic last,
                         input logic bout, input logic zero);
    chk({tag, ".vld"},  {31'd0, O_VALID}, 32'd1);
    chk({tag, ".o"},    {24'd0, O},       {24'd0, o});
    chk({tag, ".last"}, {31'd0, O_LAST},  {31'd0, last});
    chk({tag, ".bout"}, {31'd0, BOUT},    {31'd0, bout});
    chk({tag, ".zero"}, {31'd0, ZERO},    {31'd0, zero});
  endtask

  // Present one limb, transfer it on the next edge (O_READY high), sample 1ns later.
  task automatic put(input logic [7:0] a, input logic [7:0] b, input logic bi, input logic last);
    I0 = a; I1 = b; BIN = bi; I_LAST = last; I_VALID = 1'b1;
    @(posedge CLK); #1;
    I_VALID = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".vld"},  {31'd0, O_VALID}, 32'd0);
    chk({tag, ".o"},    {24'd0, O},       32'd0);
    chk({tag, ".last"}, {31'd0, O_LAST},  32'd0);
    chk({tag, ".bout"}, {31'd0, BOUT},    32'd0);
    chk({tag, ".zero"}, {31'd0, ZERO},    32'd0);
    chk({tag, ".rdy"},  {31'd0, I_READY}, 32'd1);
  endtask

  initial begin
    // Reset values while held in reset.
    O_READY = 1'b0;
    #2;
    chk_reset("rst0");
    #10 ASYNCRESETN = 1'b1;
    O_READY = 1'b1;
    @(posedge CLK); #1;

    // Single limb: 05-07 -> FE with borrow; 10-0F-1 -> 00, zero.
    put(8'h05, 8'h07, 1'b0, 1'b1);
    chk_out("single1", 8'hFE, 1'b1, 1'b1, 1'b0);
    put(8'h10, 8'h0F, 1'b1, 1'b1);
    chk_out("single2", 8'h00, 1'b1, 1'b0, 1'b1);
    @(posedge CLK); #1;
    chk("drain.vld", {31'd0, O_VALID}, 32'd0);

    // 0x0100 - 0x0001: borrow ripples into limb 1.
    put(8'h00, 8'h01, 1'b0, 1'b0);
    chk_out("chain.l0", 8'hFF, 1'b0, 1'b0, 1'b0);
    put(8'h01, 8'h00, 1'b0, 1'b1);
    chk_out("chain.l1", 8'h00, 1'b1, 1'b0, 1'b0);

    // 0 - 1 over 4 limbs, BIN high on MID limbs must be ignored.
    put(8'h00, 8'h01, 1'b0, 1'b0);
    chk_out("neg.l0", 8'hFF, 1'b0, 1'b0, 1'b0);
    put(8'h00, 8'h00, 1'b1, 1'b0);
    chk_out("neg.l1", 8'hFF, 1'b0, 1'b0, 1'b0);
    put(8'h00, 8'h00, 1'b0, 1'b0);
    chk_out("neg.l2", 8'hFF, 1'b0, 1'b0, 1'b0);
    put(8'h00, 8'h00, 1'b1, 1'b1);
    chk_out("neg.l3", 8'hFF, 1'b1, 1'b1, 1'b0);

    // 0x0202 - 0x0202 back-to-back with previous op: multi-limb zero.
    put(8'h02, 8'h02, 1'b0, 1'b0);
    chk_out("zero.l0", 8'h00, 1'b0, 1'b0, 1'b0);
    put(8'h02, 8'h02, 1'b1, 1'b1);
    chk_out("zero.l1", 8'h00, 1'b1, 1'b0, 1'b1);

    // Backpressure: 0x010000 - 0x000001, stall 3 cycles before limb 2.
    put(8'h00, 8'h01, 1'b0, 1'b0);
    chk_out("bp.l0", 8'hFF, 1'b0, 1'b0, 1'b0);
    put(8'h00, 8'h00, 1'b0, 1'b0);
    chk_out("bp.l1", 8'hFF, 1'b0, 1'b0, 1'b0);
    O_READY = 1'b0;
    I0 = 8'h01; I1 = 8'h00; I_LAST = 1'b1; I_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      BIN = i[0];
      #1;
      chk("bp.stall.rdy", {31'd0, I_READY}, 32'd0);
      @(posedge CLK); #1;
      chk_out("bp.hold", 8'hFF, 1'b0, 1'b0, 1'b0);
    end
    O_READY = 1'b1;
    BIN = 1'b1;
    #1;
    chk("bp.rel.rdy", {31'd0, I_READY}, 32'd1);
    @(posedge CLK); #1;
    I_VALID = 1'b0;
    chk_out("bp.l2", 8'h00, 1'b1, 1'b0, 1'b0);

    // Mid-operation reset discards the pending borrow.
    put(8'h00, 8'h01, 1'b0, 1'b0);
    chk_out("mrst.l0", 8'hFF, 1'b0, 1'b0, 1'b0);
    O_READY = 1'b0;
    #3 ASYNCRESETN = 1'b0;
    #1;
    chk_reset("mrst");
    O_READY = 1'b1;
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
    put(8'h00, 8'h00, 1'b0, 1'b1);
    chk_out("mrst.new", 8'h00, 1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Watchdog: the directed sequence is short; exceeding this means a hang.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sub8_bin_bout_stream.md
# sub8_bin_bout_stream

Streaming multi-limb subtractor, the inverse of the 8-bit carry-in/carry-out adder: computes A − B over operands of arbitrary length presented as a stream of `width`-bit limbs, least-significant limb first. Borrow propagates across limbs in a register, so one narrow subtract cell serves any operand length. It sits between limb-serial operand producers and consumers (bignum datapath, checksum/compare units) and uses valid/ready handshakes on both sides.

## Interface
- `width`, 8, limb width in bits (≥1)
- `CLK`  in  1  clock; all state updates on rising edge
- `ASYNCRESETN`  in  1  asynchronous, active-low reset
- `I0`  in  width  minuend limb (A)
- `I1`  in  width  subtrahend limb (B)
- `BIN`  in  1  borrow-in for the whole operation; sampled only with the first limb of an operation
- `I_VALID`  in  1  input limb valid
- `I_LAST`  in  1  marks the final (most-significant) limb of an operation
- `I_READY`  out  1  block accepts a limb this cycle
- `O`  out  width  difference limb
- `O_LAST`  out  1  accompanies the final difference limb
- `BOUT`  out  1  final borrow-out; meaningful only when `O_LAST`=1, else 0
- `ZERO`  out  1  whole multi-limb result is zero; meaningful only when `O_LAST`=1, else 0
- `O_VALID`  out  1  output limb valid
- `O_READY`  in  1  downstream accepts output limb

## Operation
- Input transfer: `I_VALID & I_READY`. Output transfer: `O_VALID & O_READY`.
- State: `FIRST` (next accepted limb starts an operation) or `MID` (continuing). Reset state `FIRST`.
- Registers: `borrow_q` (1 bit), `zero_q` (1 bit, running "all limbs zero"), output register (`O`, `O_LAST`, `BOUT`, `ZERO`, `O_VALID`).
- Borrow-in for an accepted limb: `BIN` in `FIRST`, `borrow_q` in `MID`.
- Arithmetic, `width+1` bits, zero-extended: `d = {0,I0} − {0,I1} − bin`; `O = d[width-1:0]`; limb borrow `b = d[width]` (equivalently `b = ~carry` of `I0 + ~I1 + ~bin`). Modular; no saturation.
- On accepted limb: `borrow_q ← b`; `zero_q ← (FIRST ? 1 : zero_q) & (O == 0)`; load output register; `O_LAST ← I_LAST`.
- If `I_LAST`: `BOUT ← b`, `ZERO ← zero-accumulation including this limb`, next state `FIRST`, `borrow_q` cleared. Else `BOUT ← 0`, `ZERO ← 0`, next state `MID`.
- Single-limb operation (`I_LAST`=1 in `FIRST`) is legal: behaves as plain `width`-bit subtract with borrow in/out.
- `BIN` is ignored in `MID`. `I0`/`I1`/`I_LAST` are ignored when not transferred.
- Backpressure: `I_READY = ~O_VALID | O_READY`. While stalled, output register, `borrow_q`, `zero_q` and state hold; outputs stable until transferred.
- `O_VALID` sets on input transfer; clears on output transfer with no simultaneous input transfer.

## Timing
- Reset (async assert, any cycle incl. mid-operation): `O_VALID`=0, `O`=0, `O_LAST`=0, `BOUT`=0, `ZERO`=0, `borrow_q`=0, `zero_q`=1, state `FIRST`. `I_READY`=1 while in reset. Partial operation is discarded; the first limb after reset starts a new operation using `BIN`.
- Deassertion: synchronous-safe; first transfer possible on first rising edge after release.
- Latency: 1 cycle (limb accepted at edge n is presented at `O` after edge n).
- Throughput: 1 limb/cycle with `O_READY` held high; no bubbles between operations (last limb of one and first of the next on consecutive cycles).
- Simultaneous output and input transfer in one cycle: output register replaced by new limb, `O_VALID` stays 1.
- `I_READY` is combinational from `O_READY`; no combinational path from `I_VALID` to `I_READY`.

## Test plan
- Reset values: assert `ASYNCRESETN`=0 mid-cycle → all outputs 0, `I_READY`=1 without waiting for a clock edge.
- Single limb: `I0`=0x05, `I1`=0x07, `BIN`=0, `I_LAST`=1 → next cycle `O`=0xFE, `BOUT`=1, `ZERO`=0, `O_LAST`=1; `I0`=0x10, `I1`=0x0F, `BIN`=1 → `O`=0x00, `BOUT`=0, `ZERO`=1.
- Multi-limb borrow chain: A=0x0100, B=0x0001, `BIN`=0, limbs (0x00,0x01),(0x01,0x00 last) → `O`=0xFF then 0x00, final `BOUT`=0, `ZERO`=0; A=0x0000_0000 − 1 over 4 limbs → 0xFF×4, `BOUT`=1.
- Backpressure: stream 3-limb operation with `O_READY` low for 3 cycles on limb 2 → `I_READY`=0, `O`/`borrow_q` hold, results identical to unstalled run; `BIN` toggled during `MID` has no effect.
- Back-to-back ops with mid-operation reset: reset after limb 1 of a 3-limb op, then single limb 0x00−0x00 `BIN`=0 → `O`=0x00, `BOUT`=0, `ZERO`=1 (no stale borrow).
- Random: 10k random operations, lengths 1–8 limbs, random `I_VALID`/`O_READY` → matches big-integer reference model (result mod 2^(8·n), `BOUT` = A < B + BIN).
